fetch_unit: RTL and testbench

- Program counter / fetch sequencer that drives the instruction ROM address.
- The ROM's 9-bit output feeds the control decoder; the decoder's BranchEn and Ack come back here, with the ALU condition flag, to select the next PC.
- Owns program start/finish sequencing: waits for Start, runs until the all-ones Ack instruction or end of ROM, then raises Done.

---
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Program counter / fetch sequencer for the instruction ROM. It waits for
// Start, then steps through the program one instruction per non-stalled cycle.
// It takes branches selected by the decoder (BranchEn) and the ALU (CondFlag),
// and stops on the halt instruction (Ack) or at the top of the ROM.
//
// Optional build macro: FETCH_PERF_CNT_EN
//   When defined, the CycleCnt and TakenCnt performance counters are added.
//
// Ports:
//   Clk       in   system clock, rising edge
//   Reset     in   synchronous active-high reset
//   Start     in   begin execution (accepted in IDLE/DONE when not stalled)
//   Stall     in   freeze PC and state for this cycle
//   BranchEn  in   current instruction is a branch
//   CondFlag  in   ALU condition for the current instruction
//   Target    in   absolute branch target [PC_W]
//   Ack       in   current instruction is the halt encoding
//   ProgCtr   out  registered ROM address [PC_W]
//   Valid     out  ProgCtr addresses a live instruction (RUN)
//   Done      out  program finished, sticky until next accepted Start
//   CycleCnt  out  (optional) non-stalled RUN cycles, saturating [16]
//   TakenCnt  out  (optional) taken branches, saturating [16]
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int PC_W       = 10,
    parameter int START_ADDR = 0
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Stall,
    input  logic            BranchEn,
    input  logic            CondFlag,
    input  logic [PC_W-1:0] Target,
    input  logic            Ack,
    output logic [PC_W-1:0] ProgCtr,
    output logic            Valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]     CycleCnt,
    output logic [15:0]     TakenCnt,
`endif
    output logic            Done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] PC_START = PC_W'(START_ADDR);
    localparam logic [PC_W-1:0] PC_MAX   = {PC_W{1'b1}};

    state_t          state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic            valid_reg, done_reg;
    logic            start_accept;
    logic            run_step;
    logic            branch_taken;

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        start_accept = 1'b0;
        run_step     = 1'b0;
        branch_taken = 1'b0;

        // Stall freezes everything, including acceptance of Start.
        if (!Stall) begin
            case (state_reg)
                S_RUN: begin
                    run_step = 1'b1;
                    if (Ack) begin
                        state_next = S_DONE;
                    end else if (BranchEn && CondFlag) begin
                        // Taken branches win over the end-of-ROM stop.
                        pc_next      = Target;
                        branch_taken = 1'b1;
                    end else if (pc_reg == PC_MAX) begin
                        // No wrap: falling off the top of the ROM ends the program.
                        state_next = S_DONE;
                    end else begin
                        pc_next = pc_reg + 1'b1;
                    end
                end
                default: begin
                    if (Start) begin
                        start_accept = 1'b1;
                        state_next   = S_RUN;
                        pc_next      = PC_START;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= S_IDLE;
            pc_reg    <= PC_START;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            // Flags are registered alongside the state so outputs stay pure flops.
            valid_reg <= (state_next == S_RUN);
            done_reg  <= (state_next == S_DONE);
        end
    end

    assign ProgCtr = pc_reg;
    assign Valid   = valid_reg;
    assign Done    = done_reg;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] cycle_cnt_reg;
    logic [15:0] taken_cnt_reg;

    always_ff @(posedge Clk) begin
        if (Reset || start_accept) begin
            cycle_cnt_reg <= 16'd0;
            taken_cnt_reg <= 16'd0;
        end else begin
            if (run_step && (cycle_cnt_reg != 16'hFFFF))
                cycle_cnt_reg <= cycle_cnt_reg + 16'd1;
            if (branch_taken && (taken_cnt_reg != 16'hFFFF))
                taken_cnt_reg <= taken_cnt_reg + 16'd1;
        end
    end

    assign CycleCnt = cycle_cnt_reg;
    assign TakenCnt = taken_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. Directed scenarios cover the main
// sequencing rules. A randomized run is checked cycle by cycle against a
// behavioural model of the sequencing rules. A second instance with PC_W=4
// exercises the end-of-ROM behaviour.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int PC_W  = 10;
    localparam int PC_MX = (1 << PC_W) - 1;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic            Reset, Start, Stall, BranchEn, CondFlag, Ack;
    logic [PC_W-1:0] Target;
    logic [PC_W-1:0] ProgCtr;
    logic            Valid, Done;
    logic            Reset4, Start4;
    logic [3:0]      ProgCtr4;
    logic            Valid4, Done4;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0]     CycleCnt, TakenCnt, CycleCnt4, TakenCnt4;
`endif

    int total = 0;
    int bad   = 0;

    fetch_unit #(.PC_W(PC_W), .START_ADDR(0)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
        .BranchEn(BranchEn), .CondFlag(CondFlag), .Target(Target), .Ack(Ack),
        .ProgCtr(ProgCtr), .Valid(Valid),
`ifdef FETCH_PERF_CNT_EN
        .CycleCnt(CycleCnt), .TakenCnt(TakenCnt),
`endif
        .Done(Done)
    );

    fetch_unit #(.PC_W(4), .START_ADDR(0)) dut4 (
        .Clk(Clk), .Reset(Reset4), .Start(Start4), .Stall(Stall),
        .BranchEn(BranchEn), .CondFlag(CondFlag), .Target(Target[3:0]), .Ack(Ack),
        .ProgCtr(ProgCtr4), .Valid(Valid4),
`ifdef FETCH_PERF_CNT_EN
        .CycleCnt(CycleCnt4), .TakenCnt(TakenCnt4),
`endif
        .Done(Done4)
    );

    // Behavioural model of the main instance: mode 0=idle, 1=running, 2=finished.
    int m_mode, m_pc, m_cyc, m_tak;
    bit m_done;

    function automatic void model_step();
        if (Reset) begin
            m_mode = 0; m_pc = 0; m_done = 0; m_cyc = 0; m_tak = 0;
        end else if (Stall) begin
            // frozen
        end else if (m_mode != 1) begin
            if (Start) begin
                m_mode = 1; m_pc = 0; m_done = 0; m_cyc = 0; m_tak = 0;
            end
        end else begin
            if (m_cyc < 65535) m_cyc++;
            if (Ack) begin
                m_mode = 2; m_done = 1;
            end else if (BranchEn && CondFlag) begin
                m_pc = int'(Target);
                if (m_tak < 65535) m_tak++;
            end else if (m_pc == PC_MX) begin
                m_mode = 2; m_done = 1;
            end else begin
                m_pc = m_pc + 1;
            end
        end
    endfunction

    // One clock: model advances at the edge, outputs are observed at negedge.
    task automatic tick();
        @(posedge Clk);
        model_step();
        @(negedge Clk);
    endtask

    task automatic quiet();
        Start = 0; Stall = 0; BranchEn = 0; CondFlag = 0; Ack = 0; Target = '0;
    endtask

    // Reset the main instance, start it, then advance n plain cycles.
    task automatic restart(input int n);
        quiet();
        Reset = 1; tick(); Reset = 0;
        Start = 1; tick(); Start = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        total++;
        if (ProgCtr !== 10'd0 || Valid !== 1'b0 || Done !== 1'b0) begin
            bad++;
            $display("FAIL reset: pc=%0d valid=%b done=%b expected pc=0 valid=0 done=0", ProgCtr, Valid, Done);
        end
        total++;
        if (ProgCtr4 !== 4'd0 || Valid4 !== 1'b0 || Done4 !== 1'b0) begin
            bad++;
            $display("FAIL reset4: pc=%0d valid=%b done=%b expected pc=0 valid=0 done=0", ProgCtr4, Valid4, Done4);
        end
        $display("reset: pc=%0d valid=%b done=%b", ProgCtr, Valid, Done);
    endtask

    task automatic test_sequential();
        quiet();
        Start = 1; tick(); Start = 0;
        for (int i = 0; i <= 5; i++) begin
            if (i > 0) tick();
            total++;
            if (ProgCtr !== 10'(i) || Valid !== 1'b1 || Done !== 1'b0) begin
                bad++;
                $display("FAIL seq[%0d]: pc=%0d valid=%b done=%b expected pc=%0d valid=1 done=0", i, ProgCtr, Valid, Done, i);
            end
            $display("seq: pc=%0d valid=%b done=%b", ProgCtr, Valid, Done);
        end
    endtask

    task automatic test_branch();
        restart(3);
        BranchEn = 1; CondFlag = 1; Target = 10'd40; tick(); quiet();
        total++;
        if (ProgCtr !== 10'd40 || Valid !== 1'b1) begin
            bad++;
            $display("FAIL branch_taken: pc=%0d valid=%b expected pc=40 valid=1", ProgCtr, Valid);
        end
        $display("branch taken: pc=%0d", ProgCtr);
        restart(3);
        BranchEn = 1; CondFlag = 0; Target = 10'd40; tick(); quiet();
        total++;
        if (ProgCtr !== 10'd4) begin
            bad++;
            $display("FAIL branch_not_taken: pc=%0d expected pc=4", ProgCtr);
        end
        $display("branch not taken: pc=%0d", ProgCtr);
        // Branch to own address loops.
        BranchEn = 1; CondFlag = 1; Target = 10'd4; tick(); tick(); quiet();
        total++;
        if (ProgCtr !== 10'd4 || Valid !== 1'b1) begin
            bad++;
            $display("FAIL branch_self: pc=%0d valid=%b expected pc=4 valid=1", ProgCtr, Valid);
        end
        $display("branch self: pc=%0d", ProgCtr);
    endtask

    task automatic test_ack();
        restart(7);
        Ack = 1; BranchEn = 1; CondFlag = 1; Target = 10'd99; tick(); quiet();
        total++;
        if (ProgCtr !== 10'd7 || Done !== 1'b1 || Valid !== 1'b0) begin
            bad++;
            $display("FAIL ack: pc=%0d done=%b valid=%b expected pc=7 done=1 valid=0", ProgCtr, Done, Valid);
        end
        $display("ack: pc=%0d done=%b", ProgCtr, Done);
        tick(); tick();
        total++;
        if (ProgCtr !== 10'd7 || Done !== 1'b1) begin
            bad++;
            $display("FAIL done_sticky: pc=%0d done=%b expected pc=7 done=1", ProgCtr, Done);
        end
        // Start during Stall in DONE is ignored.
        Stall = 1; Start = 1; tick(); quiet();
        total++;
        if (Done !== 1'b1 || Valid !== 1'b0 || ProgCtr !== 10'd7) begin
            bad++;
            $display("FAIL stall_start: pc=%0d done=%b valid=%b expected pc=7 done=1 valid=0", ProgCtr, Done, Valid);
        end
        Start = 1; tick(); Start = 0;
        total++;
        if (ProgCtr !== 10'd0 || Done !== 1'b0 || Valid !== 1'b1) begin
            bad++;
            $display("FAIL restart: pc=%0d done=%b valid=%b expected pc=0 done=0 valid=1", ProgCtr, Done, Valid);
        end
        $display("restart: pc=%0d done=%b valid=%b", ProgCtr, Done, Valid);
    endtask

    task automatic test_stall();
        restart(12);
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            Ack = (i == 1); Start = (i == 2);
            tick();
            total++;
            if (ProgCtr !== 10'd12 || Valid !== 1'b1 || Done !== 1'b0) begin
                bad++;
                $display("FAIL stall[%0d]: pc=%0d valid=%b done=%b expected pc=12 valid=1 done=0", i, ProgCtr, Valid, Done);
            end
            $display("stall: pc=%0d valid=%b", ProgCtr, Valid);
        end
        quiet(); tick();
        total++;
        if (ProgCtr !== 10'd13) begin
            bad++;
            $display("FAIL stall_release: pc=%0d expected pc=13", ProgCtr);
        end
        $display("stall release: pc=%0d", ProgCtr);
    endtask

    task automatic test_end_of_rom();
        quiet();
        Reset4 = 1; tick(); Reset4 = 0;
        Start4 = 1; tick(); Start4 = 0;
        for (int i = 0; i < 15; i++) tick();
        total++;
        if (ProgCtr4 !== 4'd15 || Valid4 !== 1'b1) begin
            bad++;
            $display("FAIL rom_top: pc=%0d valid=%b expected pc=15 valid=1", ProgCtr4, Valid4);
        end
        tick();
        total++;
        if (ProgCtr4 !== 4'd15 || Done4 !== 1'b1 || Valid4 !== 1'b0) begin
            bad++;
            $display("FAIL rom_end: pc=%0d done=%b valid=%b expected pc=15 done=1 valid=0", ProgCtr4, Done4, Valid4);
        end
        $display("end of rom: pc=%0d done=%b", ProgCtr4, Done4);
        // Taken branch from the top address is still honoured.
        Start4 = 1; tick(); Start4 = 0;
        for (int i = 0; i < 15; i++) tick();
        BranchEn = 1; CondFlag = 1; Target = 10'd5; tick(); quiet();
        total++;
        if (ProgCtr4 !== 4'd5 || Valid4 !== 1'b1 || Done4 !== 1'b0) begin
            bad++;
            $display("FAIL rom_top_branch: pc=%0d valid=%b done=%b expected pc=5 valid=1 done=0", ProgCtr4, Valid4, Done4);
        end
        $display("branch from top: pc=%0d", ProgCtr4);
        // Reset mid-run.
        Start4 = 0; Reset4 = 1; tick(); Reset4 = 0;
        Start4 = 1; tick(); Start4 = 0;
        for (int i = 0; i < 9; i++) tick();
        Reset4 = 1; tick(); Reset4 = 0;
        total++;
        if (ProgCtr4 !== 4'd0 || Valid4 !== 1'b0 || Done4 !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_run: pc=%0d valid=%b done=%b expected pc=0 valid=0 done=0", ProgCtr4, Valid4, Done4);
        end
        $display("reset mid run: pc=%0d valid=%b", ProgCtr4, Valid4);
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        restart(0);
        // 10 RUN steps, 2 taken branches, 3 stalls interleaved.
        for (int i = 0; i < 13; i++) begin
            quiet();
            Stall = (i == 2 || i == 6 || i == 7);
            if (i == 4 || i == 9) begin BranchEn = 1; CondFlag = 1; Target = 10'd20; end
            if (i == 11) begin BranchEn = 1; CondFlag = 0; end
            tick();
        end
        quiet();
        total++;
        if (CycleCnt !== 16'd10 || TakenCnt !== 16'd2) begin
            bad++;
            $display("FAIL perf: cycle=%0d taken=%0d expected cycle=10 taken=2", CycleCnt, TakenCnt);
        end
        $display("perf: cycle=%0d taken=%0d", CycleCnt, TakenCnt);
        Ack = 1; tick(); Ack = 0; tick();
        total++;
        if (CycleCnt !== 16'd11 || TakenCnt !== 16'd2) begin
            bad++;
            $display("FAIL perf_hold: cycle=%0d taken=%0d expected cycle=11 taken=2", CycleCnt, TakenCnt);
        end
        Start = 1; tick(); Start = 0;
        total++;
        if (CycleCnt !== 16'd0 || TakenCnt !== 16'd0) begin
            bad++;
            $display("FAIL perf_clear: cycle=%0d taken=%0d expected 0/0", CycleCnt, TakenCnt);
        end
        $display("perf clear: cycle=%0d taken=%0d", CycleCnt, TakenCnt);
    endtask
`endif

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 3000; i++) begin
            Reset    = ($urandom_range(0, 199) == 0);
            Start    = ($urandom_range(0, 19) == 0);
            Stall    = ($urandom_range(0, 4) == 0);
            Ack      = ($urandom_range(0, 49) == 0);
            BranchEn = ($urandom_range(0, 4) == 0);
            CondFlag = $urandom_range(0, 1);
            Target   = ($urandom_range(0, 3) == 0) ? 10'(1018 + $urandom_range(0, 5))
                                                   : 10'($urandom_range(0, PC_MX));
            tick();
            total++;
            if (ProgCtr !== 10'(m_pc) || Valid !== (m_mode == 1) || Done !== m_done) begin
                bad++; errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d]: pc=%0d valid=%b done=%b expected pc=%0d valid=%b done=%b",
                             i, ProgCtr, Valid, Done, m_pc, (m_mode == 1), m_done);
            end
`ifdef FETCH_PERF_CNT_EN
            total++;
            if (CycleCnt !== 16'(m_cyc) || TakenCnt !== 16'(m_tak)) begin
                bad++; errs++;
                if (errs <= 10)
                    $display("FAIL random_perf[%0d]: cycle=%0d taken=%0d expected cycle=%0d taken=%0d",
                             i, CycleCnt, TakenCnt, m_cyc, m_tak);
            end
`endif
        end
        quiet(); Reset = 0;
        $display("random: 3000 cycles, mismatching cycles=%0d", errs);
    endtask

    initial begin
        quiet();
        Reset = 1; Reset4 = 1; Start4 = 0;
        tick(); tick();
        Reset = 0; Reset4 = 0;
        test_reset();
        test_sequential();
        test_branch();
        test_ack();
        test_stall();
        test_end_of_rom();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
